// File: rtl/fu_complete_arbiter_pkg.sv
// Shared completion-path types: default widths and the CDB / ROB write packets
// used by the FU output stages, this arbiter and the ROB.
package fu_complete_arbiter_pkg;

    localparam int FU_NUM_FU = 4;
    localparam int FU_ID_W   = 4;
    localparam int FU_DATA_W = 8;

    typedef struct packed {
        logic [FU_ID_W-1:0]   id;
        logic [FU_DATA_W-1:0] val;
    } cdb_pkt_t;

    typedef struct packed {
        logic [FU_ID_W-1:0]   id;
        logic [FU_DATA_W-1:0] flags;
        logic [FU_DATA_W-1:0] wbs;
        logic [FU_DATA_W-1:0] val;
    } rob_pkt_t;

endpackage

// File: rtl/fu_complete_arbiter_if.sv
// FU completion bundle: per-FU CDB/ROB requests and payloads in, one-hot grants
// and registered CDB broadcast / ROB write out.
interface fu_complete_arbiter_if
    import fu_complete_arbiter_pkg::*;
#(
    parameter int NUM_FU = FU_NUM_FU,
    parameter int ID_W   = FU_ID_W,
    parameter int DATA_W = FU_DATA_W
);
    // Handshake: an FU holds req and payload stable until it sees its grant high
    // at a rising edge; grant high in cycle t consumes the payload at the end of
    // cycle t, and the FU may drop req or present new data in cycle t+1.
    logic                             flush;
    logic [NUM_FU-1:0]                fu_cdb_req;
    logic [NUM_FU-1:0][ID_W-1:0]      fu_cdb_id;
    logic [NUM_FU-1:0][DATA_W-1:0]    fu_cdb_val;
    logic [NUM_FU-1:0]                fu_cdb_grant;
    logic [NUM_FU-1:0]                fu_rob_req;
    logic [NUM_FU-1:0][ID_W-1:0]      fu_rob_id;
    logic [NUM_FU-1:0][DATA_W-1:0]    fu_rob_flags;
    logic [NUM_FU-1:0][DATA_W-1:0]    fu_rob_wbs;
    logic [NUM_FU-1:0][DATA_W-1:0]    fu_rob_val;
    logic [NUM_FU-1:0]                fu_rob_grant;
    logic                             rob_ready;
    logic                             cdb_valid;
    logic [ID_W-1:0]                  cdb_id;
    logic [DATA_W-1:0]                cdb_val;
    logic                             rob_wr_valid;
    logic [ID_W-1:0]                  rob_wr_id;
    logic [DATA_W-1:0]                rob_wr_flags;
    logic [DATA_W-1:0]                rob_wr_wbs;
    logic [DATA_W-1:0]                rob_wr_val;

    modport master (
        output flush, fu_cdb_req, fu_cdb_id, fu_cdb_val,
        output fu_rob_req, fu_rob_id, fu_rob_flags, fu_rob_wbs, fu_rob_val, rob_ready,
        input  fu_cdb_grant, fu_rob_grant,
        input  cdb_valid, cdb_id, cdb_val,
        input  rob_wr_valid, rob_wr_id, rob_wr_flags, rob_wr_wbs, rob_wr_val
    );

    modport slave (
        input  flush, fu_cdb_req, fu_cdb_id, fu_cdb_val,
        input  fu_rob_req, fu_rob_id, fu_rob_flags, fu_rob_wbs, fu_rob_val, rob_ready,
        output fu_cdb_grant, fu_rob_grant,
        output cdb_valid, cdb_id, cdb_val,
        output rob_wr_valid, rob_wr_id, rob_wr_flags, rob_wr_wbs, rob_wr_val
    );

endinterface

// File: rtl/fu_complete_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// pointer (wrapping), pointer moves past the winner on each grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         enable,
    output logic [N-1:0] grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        if (enable) begin
            for (int k = 0; k < N; k++) begin
                idx = PW'((int'(ptr_q) + k) % N);
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    ptr_d      = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fu_complete_arbiter.sv
// FU completion arbiter: independent round-robin grants onto the CDB and the ROB
// writeback port, with the winning payloads registered one cycle later.
module fu_complete_arbiter
    import fu_complete_arbiter_pkg::*;
#(
    parameter int NUM_FU = FU_NUM_FU,
    parameter int ID_W   = FU_ID_W,
    parameter int DATA_W = FU_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    fu_complete_arbiter_if.slave  bus
);
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] val;
    } cdb_word_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] flags;
        logic [DATA_W-1:0] wbs;
        logic [DATA_W-1:0] val;
    } rob_word_t;

    logic              cdb_en;
    logic              rob_en;
    logic [NUM_FU-1:0] cdb_grant;
    logic [NUM_FU-1:0] rob_grant;
    logic              cdb_valid_q, cdb_valid_d;
    logic              rob_valid_q, rob_valid_d;
    cdb_word_t         cdb_pkt_q, cdb_pkt_d;
    rob_word_t         rob_pkt_q, rob_pkt_d;

    // Gating by rst keeps grants low while reset is held, not just after an edge.
    assign cdb_en = rst & ~bus.flush;
    assign rob_en = rst & ~bus.flush & bus.rob_ready;

    rr_arbiter #(.N(NUM_FU)) u_cdb_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.fu_cdb_req),
        .enable (cdb_en),
        .grant  (cdb_grant)
    );

    rr_arbiter #(.N(NUM_FU)) u_rob_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.fu_rob_req),
        .enable (rob_en),
        .grant  (rob_grant)
    );

    // Payloads hold when nothing is granted; only the valid bits drop.
    always_comb begin
        cdb_valid_d = 1'b0;
        cdb_pkt_d   = cdb_pkt_q;
        rob_valid_d = 1'b0;
        rob_pkt_d   = rob_pkt_q;
        for (int i = 0; i < NUM_FU; i++) begin
            if (cdb_grant[i]) begin
                cdb_valid_d   = 1'b1;
                cdb_pkt_d.id  = bus.fu_cdb_id[i];
                cdb_pkt_d.val = bus.fu_cdb_val[i];
            end
            if (rob_grant[i]) begin
                rob_valid_d     = 1'b1;
                rob_pkt_d.id    = bus.fu_rob_id[i];
                rob_pkt_d.flags = bus.fu_rob_flags[i];
                rob_pkt_d.wbs   = bus.fu_rob_wbs[i];
                rob_pkt_d.val   = bus.fu_rob_val[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid_q <= 1'b0;
            cdb_pkt_q   <= '0;
            rob_valid_q <= 1'b0;
            rob_pkt_q   <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_pkt_q   <= cdb_pkt_d;
            rob_valid_q <= rob_valid_d;
            rob_pkt_q   <= rob_pkt_d;
        end
    end

    assign bus.fu_cdb_grant = cdb_grant;
    assign bus.fu_rob_grant = rob_grant;
    assign bus.cdb_valid    = cdb_valid_q;
    assign bus.cdb_id       = cdb_pkt_q.id;
    assign bus.cdb_val      = cdb_pkt_q.val;
    assign bus.rob_wr_valid = rob_valid_q;
    assign bus.rob_wr_id    = rob_pkt_q.id;
    assign bus.rob_wr_flags = rob_pkt_q.flags;
    assign bus.rob_wr_wbs   = rob_pkt_q.wbs;
    assign bus.rob_wr_val   = rob_pkt_q.val;

endmodule

// File: tb/tb_fu_complete_arbiter.sv
// Bench for fu_complete_arbiter: directed scenarios plus random traffic checked
// against a distance-based round-robin model and expected-packet queues.
module tb_fu_complete_arbiter;

    localparam int N  = 4;
    localparam int IW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    fu_complete_arbiter_if #(.NUM_FU(N), .ID_W(IW), .DATA_W(DW)) bus ();

    fu_complete_arbiter #(.NUM_FU(N), .ID_W(IW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- model / scoreboard state ----------------
    logic [IW+DW-1:0]   cdb_exp_q[$];
    logic [IW+3*DW-1:0] rob_exp_q[$];
    logic [IW+DW-1:0]   cdb_hold;
    logic [IW+3*DW-1:0] rob_hold;
    int                 cdb_ptr, rob_ptr, cdb_win, rob_win;
    logic [N-1:0]       dut_cdb_grant, dut_rob_grant;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner is the requester with the smallest forward distance from the pointer.
    function automatic int pick(input logic [N-1:0] req, input int ptr, input bit en);
        int best   = -1;
        int best_d = N;
        if (!en) return -1;
        for (int i = 0; i < N; i++) begin
            if (req[i] && ((i - ptr + N) % N) < best_d) begin
                best   = i;
                best_d = (i - ptr + N) % N;
            end
        end
        return best;
    endfunction

    function automatic logic [31:0] onehot(input int w);
        return (w < 0) ? 32'd0 : (32'd1 << w);
    endfunction

    task automatic model_reset();
        cdb_exp_q.delete();
        rob_exp_q.delete();
        cdb_hold = '0;
        rob_hold = '0;
        cdb_ptr  = 0;
        rob_ptr  = 0;
        cdb_win  = -1;
        rob_win  = -1;
    endtask

    // One cycle: check outputs and grants at negedge, then advance past posedge.
    task automatic step();
        logic [IW+DW-1:0]   c;
        logic [IW+3*DW-1:0] r;
        @(negedge clk);
        if (cdb_exp_q.size() > 0) begin
            c = cdb_exp_q.pop_front();
            check("cdb_valid", 32'(bus.cdb_valid), 32'd1);
            check("cdb_id",    32'(bus.cdb_id),  32'(c[IW+DW-1:DW]));
            check("cdb_val",   32'(bus.cdb_val), 32'(c[DW-1:0]));
            cdb_hold = c;
        end else begin
            check("cdb_valid",    32'(bus.cdb_valid), 32'd0);
            check("cdb_id_hold",  32'(bus.cdb_id),  32'(cdb_hold[IW+DW-1:DW]));
            check("cdb_val_hold", 32'(bus.cdb_val), 32'(cdb_hold[DW-1:0]));
        end
        if (rob_exp_q.size() > 0) begin
            r = rob_exp_q.pop_front();
            check("rob_wr_valid", 32'(bus.rob_wr_valid), 32'd1);
            check("rob_wr_id",    32'(bus.rob_wr_id),    32'(r[IW+3*DW-1:3*DW]));
            check("rob_wr_flags", 32'(bus.rob_wr_flags), 32'(r[3*DW-1:2*DW]));
            check("rob_wr_wbs",   32'(bus.rob_wr_wbs),   32'(r[2*DW-1:DW]));
            check("rob_wr_val",   32'(bus.rob_wr_val),   32'(r[DW-1:0]));
            rob_hold = r;
        end else begin
            check("rob_wr_valid",   32'(bus.rob_wr_valid), 32'd0);
            check("rob_wr_id_hold", 32'(bus.rob_wr_id),    32'(rob_hold[IW+3*DW-1:3*DW]));
            check("rob_wr_val_hold", 32'(bus.rob_wr_val),  32'(rob_hold[DW-1:0]));
        end
        cdb_win = pick(bus.fu_cdb_req, cdb_ptr, rst && !bus.flush);
        rob_win = pick(bus.fu_rob_req, rob_ptr, rst && !bus.flush && bus.rob_ready);
        dut_cdb_grant = bus.fu_cdb_grant;
        dut_rob_grant = bus.fu_rob_grant;
        check("cdb_grant", 32'(dut_cdb_grant), onehot(cdb_win));
        check("rob_grant", 32'(dut_rob_grant), onehot(rob_win));
        if (cdb_win >= 0) begin
            cdb_exp_q.push_back({bus.fu_cdb_id[cdb_win], bus.fu_cdb_val[cdb_win]});
            cdb_ptr = (cdb_win + 1) % N;
        end
        if (rob_win >= 0) begin
            rob_exp_q.push_back({bus.fu_rob_id[rob_win], bus.fu_rob_flags[rob_win],
                                 bus.fu_rob_wbs[rob_win], bus.fu_rob_val[rob_win]});
            rob_ptr = (rob_win + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        step();
        rst = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_reqs();
        bus.fu_cdb_req = '0;
        bus.fu_rob_req = '0;
        bus.flush      = 1'b0;
        bus.rob_ready  = 1'b1;
    endtask

    // FUs keep req and payload until granted; idle or just-granted FUs may issue anew.
    task automatic rand_drive();
        for (int i = 0; i < N; i++) begin
            if (cdb_win == i || !bus.fu_cdb_req[i]) begin
                bus.fu_cdb_req[i] = ($urandom_range(0, 99) < 55);
                bus.fu_cdb_id[i]  = IW'($urandom);
                bus.fu_cdb_val[i] = DW'($urandom);
            end
            if (rob_win == i || !bus.fu_rob_req[i]) begin
                bus.fu_rob_req[i]   = ($urandom_range(0, 99) < 55);
                bus.fu_rob_id[i]    = IW'($urandom);
                bus.fu_rob_flags[i] = DW'($urandom);
                bus.fu_rob_wbs[i]   = DW'($urandom);
                bus.fu_rob_val[i]   = DW'($urandom);
            end
        end
        bus.flush     = ($urandom_range(0, 99) < 8);
        bus.rob_ready = ($urandom_range(0, 99) < 75);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        bus.flush        = 1'b0;
        bus.rob_ready    = 1'b1;
        bus.fu_cdb_req   = '1;
        bus.fu_rob_req   = '1;
        bus.fu_cdb_id    = '0;
        bus.fu_cdb_val   = '0;
        bus.fu_rob_id    = '0;
        bus.fu_rob_flags = '0;
        bus.fu_rob_wbs   = '0;
        bus.fu_rob_val   = '0;

        // Reset held with all requesting: no grants, no valids.
        step();
        check("rst_cdb_grant", 32'(dut_cdb_grant), 32'd0);
        check("rst_rob_grant", 32'(dut_rob_grant), 32'd0);
        step();
        rst = 1'b1;
        step();
        check("first_cdb_grant", 32'(dut_cdb_grant), 32'b0001);
        check("first_rob_grant", 32'(dut_rob_grant), 32'b0001);

        // Single FU2 on the CDB.
        clear_reqs();
        bus.fu_cdb_req    = 4'b0100;
        bus.fu_cdb_id[2]  = 4'd5;
        bus.fu_cdb_val[2] = 8'h3C;
        step();
        check("single_grant", 32'(dut_cdb_grant), 32'b0100);
        check("single_valid", 32'(bus.cdb_valid), 32'd1);
        check("single_id",    32'(bus.cdb_id),    32'd5);
        check("single_val",   32'(bus.cdb_val),   32'h3C);
        bus.fu_cdb_req = '0;
        step();

        // Fairness: all request continuously from pointer 0.
        do_reset();
        clear_reqs();
        for (int i = 0; i < N; i++) begin
            bus.fu_cdb_id[i]  = IW'(i + 8);
            bus.fu_cdb_val[i] = DW'(8'hA0 + i);
        end
        bus.fu_cdb_req = '1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_order", 32'(dut_cdb_grant), 32'd1 << (k % N));
        end
        bus.fu_cdb_req = '0;
        step();

        // Backpressure on the ROB path.
        clear_reqs();
        bus.fu_rob_req      = 4'b0010;
        bus.fu_rob_id[1]    = 4'd9;
        bus.fu_rob_flags[1] = 8'hA5;
        bus.fu_rob_wbs[1]   = 8'h5A;
        bus.fu_rob_val[1]   = 8'h77;
        bus.rob_ready       = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_grant", 32'(dut_rob_grant), 32'd0);
            check("bp_valid", 32'(bus.rob_wr_valid), 32'd0);
        end
        bus.rob_ready = 1'b1;
        step();
        check("bp_release_grant", 32'(dut_rob_grant), 32'b0010);
        check("bp_wr_id",    32'(bus.rob_wr_id),    32'd9);
        check("bp_wr_flags", 32'(bus.rob_wr_flags), 32'hA5);
        check("bp_wr_wbs",   32'(bus.rob_wr_wbs),   32'h5A);
        check("bp_wr_val",   32'(bus.rob_wr_val),   32'h77);
        bus.fu_rob_req = '0;

        // Flush right after a grant.
        do_reset();
        clear_reqs();
        bus.fu_cdb_req    = 4'b0001;
        bus.fu_cdb_id[0]  = 4'd1;
        bus.fu_cdb_val[0] = 8'h11;
        step();
        check("fl_grant_t", 32'(dut_cdb_grant), 32'b0001);
        bus.fu_cdb_req    = 4'b1000;
        bus.fu_cdb_id[3]  = 4'd3;
        bus.fu_cdb_val[3] = 8'h33;
        bus.flush         = 1'b1;
        step();
        check("fl_grant_t1", 32'(dut_cdb_grant), 32'd0);
        check("fl_valid_t2", 32'(bus.cdb_valid), 32'd0);
        bus.flush = 1'b0;
        step();
        check("fl_grant_t2", 32'(dut_cdb_grant), 32'b1000);
        check("fl_id_t3",    32'(bus.cdb_id),    32'd3);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            rand_drive();
            step();
        end

        // Asynchronous reset between edges while broadcasting.
        clear_reqs();
        bus.fu_cdb_req = '1;
        bus.fu_rob_req = '1;
        step();
        #2;
        rst = 1'b0;
        #1;
        check("async_cdb_valid", 32'(bus.cdb_valid),    32'd0);
        check("async_rob_valid", 32'(bus.rob_wr_valid), 32'd0);
        model_reset();
        step();
        step();
        rst = 1'b1;
        step();
        check("post_rst_cdb_grant", 32'(dut_cdb_grant), 32'b0001);
        check("post_rst_rob_grant", 32'(dut_rob_grant), 32'b0001);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
